// File: rtl/mux16_rr_arbiter.sv
// mux16_rr_arbiter: round-robin owner of a shared 16:1 bit mux with a per-grant burst limit
module mux16_rr_arbiter #(
    parameter int MAX_BURST = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] req,
    output logic [15:0] gnt,
    output logic [3:0]  sel,
    output logic        busy,
    output logic [3:0]  burst_cnt
);
    typedef enum logic {IDLE, OWNED} state_t;
    state_t      state_q, state_d;
    logic [15:0] gnt_q, gnt_d;
    logic [3:0]  sel_q, sel_d;
    logic        busy_q, busy_d;
    logic [3:0]  burst_q, burst_d;
    logic [3:0]  last_q, last_d;
    logic [3:0]  start, idx, pick;
    logic [15:0] cand;
    logic        found, keep;

    // find the first candidate after the current owner (or after last grant when idle), never the owner itself
    always_comb begin
        start = (state_q == IDLE) ? last_q + 4'd1 : sel_q + 4'd1;
        cand  = (state_q == IDLE) ? req : req & ~(16'd1 << sel_q);
        found = 1'b0;
        pick  = 4'd0;
        idx   = 4'd0;
        for (int i = 15; i >= 0; i--) begin
            idx = start + 4'(i);
            if (cand[idx]) begin
                found = 1'b1;
                pick  = idx;
            end
        end
    end

    // next owner: keep while under the burst limit, else hand over, else regrant alone or go idle
    always_comb begin
        keep    = state_q == OWNED && req[sel_q];
        state_d = state_q;
        gnt_d   = gnt_q;
        sel_d   = sel_q;
        last_d  = last_q;
        burst_d = burst_q;
        if (keep && burst_q != 4'(MAX_BURST - 1)) begin
            burst_d = burst_q + 4'd1;
        end else if (found) begin
            state_d = OWNED;
            gnt_d   = 16'd1 << pick;
            sel_d   = pick;
            last_d  = pick;
            burst_d = 4'd0;
        end else if (keep) begin
            burst_d = 4'd0;
        end else begin
            state_d = IDLE;
            gnt_d   = 16'd0;
            burst_d = 4'd0;
        end
        busy_d = |gnt_d;
    end

    // register all outputs; reset points the search at index 0
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            gnt_q   <= 16'd0;
            sel_q   <= 4'd0;
            busy_q  <= 1'b0;
            burst_q <= 4'd0;
            last_q  <= 4'd15;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            sel_q   <= sel_d;
            busy_q  <= busy_d;
            burst_q <= burst_d;
            last_q  <= last_d;
        end
    end

    assign gnt       = gnt_q;
    assign sel       = sel_q;
    assign busy      = busy_q;
    assign burst_cnt = burst_q;
endmodule

// File: tb/tb_mux16_rr_arbiter.sv
// tb_mux16_rr_arbiter: directed and random checks of two arbiter instances against a queue-free reference model
module tb_mux16_rr_arbiter;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [15:0] req = 16'd0;
    logic [15:0] gnt_a, gnt_b;
    logic [3:0]  sel_a, sel_b, bc_a, bc_b;
    logic        busy_a, busy_b;
    int tests = 0;
    int fails = 0;
    int m_own[2], m_last[2], m_cnt[2], m_sel[2];
    int mb[2] = '{4, 2};

    mux16_rr_arbiter #(.MAX_BURST(4)) dut_a (.clk(clk), .rst_n(rst_n), .req(req), .gnt(gnt_a), .sel(sel_a), .busy(busy_a), .burst_cnt(bc_a));
    mux16_rr_arbiter #(.MAX_BURST(2)) dut_b (.clk(clk), .rst_n(rst_n), .req(req), .gnt(gnt_b), .sel(sel_b), .busy(busy_b), .burst_cnt(bc_b));

    always #5 clk = ~clk;

    function automatic int find(input int from, input int excl, input logic [15:0] r);
        for (int off = 0; off < 16; off++) begin
            int j;
            j = (from + off) % 16;
            if (j != excl && r[j]) return j;
        end
        return -1;
    endfunction

    task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s got %h exp %h", tag, got, exp);
        end
    endtask

    task automatic model(input logic [15:0] r, input logic rn);
        for (int d = 0; d < 2; d++) begin
            int j;
            if (!rn) begin
                m_own[d] = -1; m_last[d] = 15; m_cnt[d] = 0; m_sel[d] = 0;
            end else if (m_own[d] < 0) begin
                j = find(m_last[d] + 1, -1, r);
                if (j >= 0) begin
                    m_own[d] = j; m_last[d] = j; m_cnt[d] = 0; m_sel[d] = j;
                end
            end else if (!r[m_own[d]] || m_cnt[d] == mb[d] - 1) begin
                j = find(m_own[d] + 1, m_own[d], r);
                if (j >= 0) begin
                    m_own[d] = j; m_last[d] = j; m_cnt[d] = 0; m_sel[d] = j;
                end else begin
                    if (!r[m_own[d]]) m_own[d] = -1;
                    m_cnt[d] = 0;
                end
            end else begin
                m_cnt[d]++;
            end
        end
    endtask

    task automatic compare();
        logic [15:0] eg[2];
        for (int d = 0; d < 2; d++) eg[d] = (m_own[d] < 0) ? 16'd0 : 16'd1 << m_own[d];
        chk("gnt_a", gnt_a, eg[0]);
        chk("sel_a", {12'd0, sel_a}, 16'(m_sel[0]));
        chk("busy_a", {15'd0, busy_a}, {15'd0, m_own[0] >= 0});
        chk("burst_a", {12'd0, bc_a}, 16'(m_cnt[0]));
        chk("gnt_b", gnt_b, eg[1]);
        chk("sel_b", {12'd0, sel_b}, 16'(m_sel[1]));
        chk("busy_b", {15'd0, busy_b}, {15'd0, m_own[1] >= 0});
        chk("burst_b", {12'd0, bc_b}, 16'(m_cnt[1]));
        chk("onehot_a", {15'd0, $onehot0(gnt_a)}, 16'd1);
    endtask

    task automatic step(input logic [15:0] r, input logic rn);
        req = r;
        rst_n = rn;
        @(posedge clk);
        model(r, rn);
        #1;
        compare();
    endtask

    task automatic rst2();
        step(16'd0, 1'b0);
        step(16'd0, 1'b0);
    endtask

    initial begin
        rst2();
        chk("rst_gnt", gnt_a, 16'h0000);
        step(16'h0020, 1'b1);
        chk("single_gnt", gnt_a, 16'h0020);
        chk("single_sel", {12'd0, sel_a}, 16'd5);
        step(16'h0000, 1'b1);
        chk("drop_busy", {15'd0, busy_a}, 16'd0);
        chk("drop_sel", {12'd0, sel_a}, 16'd5);

        rst2();
        step(16'h1101, 1'b1);
        chk("rr0", {12'd0, sel_a}, 16'd0);
        step(16'h1100, 1'b1);
        chk("rr8", {12'd0, sel_a}, 16'd8);
        step(16'h1001, 1'b1);
        chk("rr12", {12'd0, sel_a}, 16'd12);
        step(16'h0101, 1'b1);
        chk("rr0b", {12'd0, sel_a}, 16'd0);
        chk("rr_busy", {15'd0, busy_a}, 16'd1);

        rst2();
        for (int i = 0; i < 12; i++) begin
            step(16'h0011, 1'b1);
            chk("burst_sel", {12'd0, sel_a}, (i / 4) % 2 == 1 ? 16'd4 : 16'd0);
            chk("burst_cnt", {12'd0, bc_a}, 16'(i % 4));
        end

        rst2();
        for (int i = 0; i < 6; i++) begin
            step(16'h8000, 1'b1);
            chk("lone_gnt", gnt_b, 16'h8000);
            chk("lone_cnt", {12'd0, bc_b}, 16'(i % 2));
        end
        step(16'h0003, 1'b1);
        chk("wrap0", {12'd0, sel_a}, 16'd0);
        step(16'h0002, 1'b1);
        chk("wrap1", {12'd0, sel_a}, 16'd1);

        rst2();
        for (int i = 0; i < 3; i++) step(16'h0C00, 1'b1);
        chk("mid_cnt", {12'd0, bc_a}, 16'd2);
        step(16'h0C00, 1'b0);
        chk("mid_rst_gnt", gnt_a, 16'h0000);
        chk("mid_rst_sel", {12'd0, sel_a}, 16'd0);
        step(16'h0C00, 1'b1);
        chk("mid_regrant", {12'd0, sel_a}, 16'd10);

        for (int i = 0; i < 400; i++) begin
            logic [15:0] r;
            r = 16'($urandom) & 16'($urandom) & 16'($urandom);
            step(r, $urandom_range(0, 63) != 0);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
